hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core.
- Sits beside the operand forwarding unit.
- Generates PC and pipeline-register enable, flush and select controls for:
  - load-use bubbles, the one case forwarding cannot cover;
  - taken branch/jump redirects resolved in EX;
  - data-memory wait states.
- Also runs a post-reset pipeline-clear sequence, a memory-timeout watchdog and two performance counters.

---
 rtl/hazard_controller_pkg.sv | 45 ++++
 rtl/hazard_controller_detect.sv | 34 +++
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared opcode constants, NOP encoding, controller state and control bundle
// for the 5-stage core's hazard and forwarding logic.
package hazard_controller_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_INIT   = '{pc_en: 1'b0, pc_sel: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                      idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '0;
    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, pc_sel: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};
    localparam ctrl_t CTRL_REDIR  = '{pc_en: 1'b1, pc_sel: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1,
                                      idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, pc_sel: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1};

endpackage

// File: rtl/hazard_controller_detect.sv
// Load-use decode: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
    import hazard_controller_pkg::*;
#(
    parameter int INST_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5
) (
    input  logic [INST_LENGTH-1:0] inst_id,
    input  logic [INST_LENGTH-1:0] inst_ex,
    output logic                   load_use
);

    logic [6:0]                 opc_id, opc_ex;
    logic [REG_ADDR_LENGTH-1:0] rd_ex, rs1_id, rs2_id;
    logic                       uses_rs1, uses_rs2;
    logic                       unused_bits;

    assign opc_id = inst_id[6:0];
    assign opc_ex = inst_ex[6:0];
    assign rd_ex  = inst_ex[7 +: REG_ADDR_LENGTH];
    assign rs1_id = inst_id[15 +: REG_ADDR_LENGTH];
    assign rs2_id = inst_id[20 +: REG_ADDR_LENGTH];

    // U-type and JAL carry immediate bits where rs1 would sit
    assign uses_rs1 = !(opc_id == OPC_LUI || opc_id == OPC_AUIPC || opc_id == OPC_JAL);
    assign uses_rs2 = (opc_id == OPC_OP) || (opc_id == OPC_STORE) || (opc_id == OPC_BRANCH);

    assign load_use = (opc_ex == OPC_LOAD) && (rd_ex != '0) &&
                      ((uses_rs1 && rs1_id == rd_ex) || (uses_rs2 && rs2_id == rd_ex));

    assign unused_bits = ^{inst_id[INST_LENGTH-1:20+REG_ADDR_LENGTH], inst_id[14:7],
                           inst_ex[INST_LENGTH-1:7+REG_ADDR_LENGTH]};

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: post-reset clear, memory freeze with timeout
// watchdog, redirect flushes, load-use bubbles and stall/redirect counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int INST_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int INIT_CYCLES     = 4,
    parameter int MEM_TIMEOUT     = 64,
    parameter int CNT_W           = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_LENGTH-1:0] inst_id,
    input  logic [INST_LENGTH-1:0] inst_ex,
    input  logic                   branch_taken_ex,
    input  logic                   jump_ex,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   pc_sel,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_en,
    output logic                   idex_flush,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   halted,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       flush_events
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   init_q, init_d;
    logic [TW-1:0]   to_q, to_d, to_next;
    logic            load_use, redirect, mem_stall, freeze;
    logic            stall_inc, flush_inc, err_set;
    ctrl_t           ctrl;

    hazard_detect #(
        .INST_LENGTH     (INST_LENGTH),
        .REG_ADDR_LENGTH (REG_ADDR_LENGTH)
    ) u_detect (
        .inst_id  (inst_id),
        .inst_ex  (inst_ex),
        .load_use (load_use)
    );

    assign redirect  = branch_taken_ex | jump_ex;
    assign mem_stall = dmem_req & ~dmem_ready;
    assign freeze    = (state_q == ST_RUN) ? mem_stall : ~dmem_ready;
    assign to_next   = (state_q == ST_RUN) ? TW'(1) : to_q + TW'(1);

    always_comb begin
        ctrl      = CTRL_INIT;
        state_d   = state_q;
        init_d    = init_q;
        to_d      = to_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_q == IW'(INIT_CYCLES - 1)) state_d = ST_RUN;
                else                                init_d  = init_q + IW'(1);
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze) begin
                    ctrl      = CTRL_FREEZE;
                    stall_inc = 1'b1;
                    to_d      = to_next;
                    if (to_next == TW'(MEM_TIMEOUT)) begin
                        state_d = ST_ERROR;
                        err_set = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    // Release cycle from MEM_WAIT decodes the same as a normal RUN cycle
                    state_d = ST_RUN;
                    if (redirect) begin
                        ctrl      = CTRL_REDIR;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        ctrl      = CTRL_BUBBLE;
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = CTRL_RUN;
                    end
                end
            end
            ST_ERROR: ctrl = CTRL_FREEZE;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_q       <= '0;
            to_q         <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            to_q    <= to_d;
            if (err_set)   mem_err      <= 1'b1;
            if (stall_inc) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc) flush_events <= flush_events + CNT_W'(1);
        end
    end

    assign halted     = (state_q == ST_ERROR);
    assign pc_en      = ctrl.pc_en;
    assign pc_sel     = ctrl.pc_sel;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_en    = ctrl.idex_en;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios then random traffic.
module tb_hazard_controller;

    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int CMASK       = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW5 = 32'h0000_A283;
    localparam logic [31:0] LW0 = 32'h0000_A003;
    localparam logic [31:0] ADD = 32'h0072_8333;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] inst_id = NOP, inst_ex = NOP;
    logic branch_taken_ex = 1'b0, jump_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    hazard_controller #(
        .INST_LENGTH(32), .REG_ADDR_LENGTH(5), .INIT_CYCLES(INIT_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_ex(inst_ex),
        .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halted(halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    typedef struct packed {
        logic [9:0] ctl;   // pc_en pc_sel ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en halted mem_err
        int         stall;
        int         flush;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc_n = 0;

    // Reference model: plain counters and flags derived from the behavioural rules
    int init_left = INIT_CYCLES, wait_len = 0, m_stall = 0, m_flush = 0;
    bit waiting = 0, errored = 0;

    function automatic bit is_load_use(logic [31:0] id, logic [31:0] ex);
        logic [6:0] op;
        bit r1, r2;
        op = id[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return ex[6:0] == 7'b0000011 && ex[11:7] != 0 &&
               ((r1 && id[19:15] == ex[11:7]) || (r2 && id[24:20] == ex[11:7]));
    endfunction

    task automatic cyc(bit r, logic [31:0] id, logic [31:0] ex, bit bt, bit j, bit rq, bit rdy);
        exp_t e;
        rst = r; inst_id = id; inst_ex = ex; branch_taken_ex = bt; jump_ex = j;
        dmem_req = rq; dmem_ready = rdy;
        if (r) begin
            init_left = INIT_CYCLES; waiting = 0; wait_len = 0; errored = 0;
            m_stall = 0; m_flush = 0;
        end
        e.stall = m_stall & CMASK;
        e.flush = m_flush & CMASK;
        if (r) begin
            e.ctl = 10'b00_0101_0000;
        end else if (errored) begin
            e.ctl = 10'b00_0000_0011;
        end else if (init_left > 0) begin
            e.ctl = 10'b00_0101_0000;
            init_left--;
        end else if (waiting ? !rdy : (rq && !rdy)) begin
            e.ctl = 10'b0;
            wait_len = waiting ? wait_len + 1 : 1;
            waiting = 1;
            m_stall++;
            if (wait_len >= MEM_TIMEOUT) errored = 1;
        end else begin
            waiting = 0;
            if (bt || j) begin
                e.ctl = 10'b11_0101_1100;
                m_flush++;
            end else if (is_load_use(id, ex)) begin
                e.ctl = 10'b00_0001_1100;
                m_stall++;
            end else begin
                e.ctl = 10'b10_1010_1100;
            end
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc_n++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, NOP, NOP, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [9:0] got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, memwb_en, halted, mem_err};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl cycle %0d: got %b want %b", cyc_n, got, e.ctl);
            end
            checks++;
            if (stall_cycles !== CNT_W'(e.stall)) begin
                errors++;
                $display("FAIL stall_cycles cycle %0d: got %0d want %0d", cyc_n, stall_cycles, e.stall);
            end
            checks++;
            if (flush_events !== CNT_W'(e.flush)) begin
                errors++;
                $display("FAIL flush_events cycle %0d: got %0d want %0d", cyc_n, flush_events, e.flush);
            end
        end
    end

    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops[8];
        logic [31:0] x;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111};
        x = $urandom;
        x[6:0]   = ops[$urandom_range(0, 7)];
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        return x;
    endfunction

    initial begin
        @(posedge clk); #1;
        cyc(1, NOP, NOP, 0, 0, 0, 0);
        cyc(1, NOP, NOP, 0, 0, 0, 0);
        idle(INIT_CYCLES + 3);
        // load-use bubble, then the bubble moves on
        cyc(0, ADD, LW5, 0, 0, 0, 1);
        cyc(0, ADD, NOP, 0, 0, 0, 1);
        idle(2);
        // rd = x0 never stalls
        cyc(0, ADD, LW0, 0, 0, 0, 1);
        idle(2);
        // redirect wins over load-use
        cyc(0, ADD, LW5, 1, 0, 0, 1);
        idle(2);
        // three wait cycles with a jump held, released on ready
        for (int i = 0; i < 3; i++) cyc(0, NOP, NOP, 0, 1, 1, 0);
        cyc(0, NOP, NOP, 0, 1, 1, 1);
        idle(2);
        // watchdog timeout, then async reset out of ERROR
        for (int i = 0; i < MEM_TIMEOUT + 4; i++) cyc(0, NOP, NOP, 0, 0, 1, 0);
        cyc(1, NOP, NOP, 0, 0, 1, 0);
        cyc(1, NOP, NOP, 0, 0, 0, 0);
        idle(INIT_CYCLES + 1);
        // stall counter wraps past 2^CNT_W-1
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            cyc(0, ADD, LW5, 0, 0, 0, 1);
            cyc(0, ADD, NOP, 0, 0, 0, 1);
        end
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, bt, j, rq, rdy;
            r   = ($urandom_range(0, 299) == 0);
            bt  = ($urandom_range(0, 7) == 0);
            j   = ($urandom_range(0, 15) == 0);
            rq  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < MEM_TIMEOUT + 2; k++) cyc(0, rnd_inst(), rnd_inst(), bt, j, 1, 0);
            end
            cyc(r, rnd_inst(), rnd_inst(), bt, j, rq, rdy);
        end
        idle(2);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
